sccb_bus_arbiter: RTL

- Shares the single OV7670 SCCB/I2C master (GO/WR/END/ACK controller, slave ID 8'h42) between NUM_REQ requesters, e.g. boot-time register LUT sequencer and runtime remote-control tuning (brightness, contrast, mirror).
- Round-robin grant, one transaction at a time, bounded retry on NACK, timeout if the controller never starts.
- Sits between requesters and the I2C controller; all sequencing is qualified by the controller's SCLK-derived enable strobe.

---
 rtl/sccb_pkg.sv | 19 +
 rtl/sccb_bus_arbiter_rr_pick.sv | 31 +++
 rtl/sccb_bus_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sccb_pkg.sv
// Shared definitions for the OV7670 SCCB bus arbiter: default slave ID,
// arbiter FSM encoding and the field layout of the controller write word.
package sccb_pkg;

  localparam logic [7:0] OV7670_ID = 8'h42;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_XFER,
    ST_RELAUNCH,
    ST_FINISH
  } state_t;

  localparam int WD_ID_LSB   = 16;
  localparam int WD_ADDR_LSB = 8;
  localparam int WD_DATA_LSB = 0;

endpackage

// File: rtl/sccb_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N; returns one-hot, index and an any-request flag.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [PW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    j    = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any     = 1'b1;
        pick[j] = 1'b1;
        idx     = PW'(j);
      end
    end
  end

endmodule

// File: rtl/sccb_bus_arbiter.sv
// Round-robin arbiter sharing one SCCB/I2C master between NUM_REQ requesters,
// with bounded NACK retry and a start timeout; advances only on i2c_en.
module sccb_bus_arbiter
  import sccb_pkg::*;
#(
  parameter int         NUM_REQ   = 2,
  parameter logic [7:0] SLAVE_ID  = OV7670_ID,
  parameter int         MAX_RETRY = 3,
  parameter int         TIMEOUT   = 64
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 i2c_en,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_wr,
  input  logic [8*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic [NUM_REQ-1:0]   err,
  output logic [7:0]           rdata,
  output logic                 busy,
  output logic                 ctrl_go,
  output logic                 ctrl_wr,
  output logic [23:0]          ctrl_wdata,
  input  logic                 ctrl_end,
  input  logic                 ctrl_ack,
  input  logic [7:0]           ctrl_rdata
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t               state_reg,   state_next;
  logic [PW-1:0]        owner_reg,   owner_next;
  logic [PW-1:0]        rr_reg,      rr_next;
  logic                 wr_reg,      wr_next;
  logic [TW-1:0]        timer_reg,   timer_next;
  logic [RW-1:0]        retry_reg,   retry_next;
  logic                 fail_reg,    fail_next;
  logic [NUM_REQ-1:0]   grant_reg,   grant_next;
  logic [NUM_REQ-1:0]   done_reg,    done_next;
  logic [NUM_REQ-1:0]   err_reg,     err_next;
  logic [7:0]           rdata_reg,   rdata_next;
  logic                 go_reg,      go_next;
  logic                 cwr_reg,     cwr_next;
  logic [23:0]          wdata_reg,   wdata_next;

  logic [NUM_REQ-1:0]   pick_onehot;
  logic [PW-1:0]        pick_idx;
  logic                 pick_any;

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req  (req),
    .ptr  (rr_reg),
    .pick (pick_onehot),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_reg <= ST_IDLE;
      owner_reg <= '0;
      rr_reg    <= '0;
      wr_reg    <= 1'b0;
      timer_reg <= '0;
      retry_reg <= '0;
      fail_reg  <= 1'b0;
      grant_reg <= '0;
      done_reg  <= '0;
      err_reg   <= '0;
      rdata_reg <= '0;
      go_reg    <= 1'b0;
      cwr_reg   <= 1'b0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      rr_reg    <= rr_next;
      wr_reg    <= wr_next;
      timer_reg <= timer_next;
      retry_reg <= retry_next;
      fail_reg  <= fail_next;
      grant_reg <= grant_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      rdata_reg <= rdata_next;
      go_reg    <= go_next;
      cwr_reg   <= cwr_next;
      wdata_reg <= wdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    rr_next    = rr_reg;
    wr_next    = wr_reg;
    timer_next = timer_reg;
    retry_next = retry_reg;
    fail_next  = fail_reg;
    grant_next = grant_reg;
    done_next  = '0;
    err_next   = '0;
    rdata_next = rdata_reg;
    go_next    = go_reg;
    cwr_next   = cwr_reg;
    wdata_next = wdata_reg;

    if (i2c_en) begin
      case (state_reg)
        ST_IDLE: begin
          if (pick_any) begin
            // wdata_reg doubles as the latched addr/data payload for retries
            owner_next = pick_idx;
            wr_next    = req_wr[pick_idx];
            cwr_next   = req_wr[pick_idx];
            grant_next = pick_onehot;
            wdata_next[WD_ID_LSB   +: 8] = SLAVE_ID;
            wdata_next[WD_ADDR_LSB +: 8] = req_addr[int'(pick_idx)*8 +: 8];
            wdata_next[WD_DATA_LSB +: 8] = req_data[int'(pick_idx)*8 +: 8];
            go_next    = 1'b1;
            timer_next = '0;
            fail_next  = 1'b0;
            state_next = ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          if (!ctrl_end) begin
            timer_next = '0;
            state_next = ST_XFER;
          end else if (timer_reg == TW'(TIMEOUT - 1)) begin
            go_next    = 1'b0;
            cwr_next   = 1'b0;
            fail_next  = 1'b1;
            state_next = ST_FINISH;
          end else begin
            timer_next = timer_reg + TW'(1);
          end
        end
        ST_XFER: begin
          if (ctrl_end) begin
            go_next  = 1'b0;
            cwr_next = 1'b0;
            if (!ctrl_ack) begin
              fail_next  = 1'b0;
              if (!wr_reg) rdata_next = ctrl_rdata;
              state_next = ST_FINISH;
            end else if (int'(retry_reg) < MAX_RETRY) begin
              retry_next = retry_reg + RW'(1);
              state_next = ST_RELAUNCH;
            end else begin
              fail_next  = 1'b1;
              state_next = ST_FINISH;
            end
          end
        end
        ST_RELAUNCH: begin
          // GO was low for this strobe, so re-raising it forms a fresh edge
          go_next    = 1'b1;
          cwr_next   = wr_reg;
          timer_next = '0;
          state_next = ST_LAUNCH;
        end
        ST_FINISH: begin
          if (fail_reg) err_next  = grant_reg;
          else          done_next = grant_reg;
          grant_next = '0;
          rr_next    = (int'(owner_reg) == NUM_REQ - 1) ? '0 : owner_reg + PW'(1);
          retry_next = '0;
          timer_next = '0;
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign grant      = grant_reg;
  assign done       = done_reg;
  assign err        = err_reg;
  assign rdata      = rdata_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign ctrl_go    = go_reg;
  assign ctrl_wr    = cwr_reg;
  assign ctrl_wdata = wdata_reg;

endmodule
